// File: rtl/hex_word_serializer_pkg.sv
// Shared constants and state encoding for the hex word serializer.
// ASCII anchors for digit conversion plus the controller state set.
package hex_pkg;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_UA = 8'h41;
    localparam logic [7:0] ASC_LA = 8'h61;
    localparam logic [7:0] ASC_X  = 8'h78;

    typedef enum logic [1:0] {
        IDLE,
        PFX0,
        PFX1,
        DIGIT
    } state_t;

endpackage

// File: rtl/hex_word_serializer_n2a.sv
// Combinational nibble to ASCII hex digit converter.
// Case of the letter digits is chosen by i_upper.
module nibble_to_ascii
    import hex_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_upper,
    output logic [7:0] o_ascii
);

    logic [7:0] w_nib;
    logic [7:0] w_base;

    assign w_nib  = {4'b0000, i_nibble};
    assign w_base = i_upper ? ASC_UA : ASC_LA;

    always_comb begin
        o_ascii = ASC_0 + w_nib;
        if (i_nibble > 4'd9)
            o_ascii = w_base + w_nib - 8'd10;
    end

endmodule

// File: rtl/hex_word_serializer.sv
// Streams a binary word as ASCII hex digits, MSB nibble first,
// with an optional "0x" prefix, over valid/ready handshakes.
module hex_word_serializer
    import hex_pkg::*;
#(
    parameter int WORD_W      = 16,
    parameter int UPPERCASE   = 1,
    parameter int EMIT_PREFIX = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [WORD_W-1:0] i_word,
    output logic              o_char_valid,
    input  logic              i_char_ready,
    output logic [7:0]        o_char,
    output logic              o_last,
    output logic              o_busy
);

    localparam int NIB = WORD_W / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    state_t            r_state;
    state_t            w_next;
    logic [WORD_W-1:0] r_shreg;
    logic [CW-1:0]     r_cnt;
    logic              w_load;
    logic              w_shift;
    logic [7:0]        w_digit;

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_load = 1'b1;
                    w_next = (EMIT_PREFIX != 0) ? PFX0 : DIGIT;
                end
            end
            PFX0:
                if (i_char_ready) w_next = PFX1;
            PFX1:
                if (i_char_ready) w_next = DIGIT;
            DIGIT: begin
                if (i_char_ready) begin
                    if (r_cnt == '0) w_next  = IDLE;
                    else             w_shift = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_shreg <= i_word;
                r_cnt   <= CW'(NIB - 1);
            end else if (w_shift) begin
                r_shreg <= r_shreg << 4;
                r_cnt   <= r_cnt - CW'(1);
            end
        end
    end

    nibble_to_ascii u_n2a (
        .i_nibble (r_shreg[WORD_W-1 -: 4]),
        .i_upper  (UPPERCASE != 0),
        .o_ascii  (w_digit)
    );

    // Outputs depend only on registered state, never on inputs.
    always_comb begin
        o_char = 8'h00;
        unique case (r_state)
            PFX0:    o_char = ASC_0;
            PFX1:    o_char = ASC_X;
            DIGIT:   o_char = w_digit;
            default: o_char = 8'h00;
        endcase
    end

    assign o_ready      = (r_state == IDLE);
    assign o_char_valid = (r_state != IDLE);
    assign o_busy       = (r_state != IDLE);
    assign o_last       = (r_state == DIGIT) && (r_cnt == '0);

endmodule

// File: tb/tb_hex_word_serializer.sv
// Self-checking bench: three serializer configurations driven by directed
// and random words, checked against an arithmetic hex-string model.
module tb_hex_word_serializer;

    logic        clk;
    logic        rst_n;
    logic [63:0] wd;
    logic        vld  [3];
    logic        crdy [3];
    logic        rdy  [3];
    logic        cv   [3];
    logic [7:0]  ch   [3];
    logic        lst  [3];
    logic        bsy  [3];

    int vecs;
    int errs;

    // 0: 16-bit upper no prefix, 1: 16-bit lower prefix, 2: 64-bit upper
    hex_word_serializer #(.WORD_W(16), .UPPERCASE(1), .EMIT_PREFIX(0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[0]), .o_ready(rdy[0]),
        .i_word(wd[15:0]), .o_char_valid(cv[0]), .i_char_ready(crdy[0]),
        .o_char(ch[0]), .o_last(lst[0]), .o_busy(bsy[0]));

    hex_word_serializer #(.WORD_W(16), .UPPERCASE(0), .EMIT_PREFIX(1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[1]), .o_ready(rdy[1]),
        .i_word(wd[15:0]), .o_char_valid(cv[1]), .i_char_ready(crdy[1]),
        .o_char(ch[1]), .o_last(lst[1]), .o_busy(bsy[1]));

    hex_word_serializer #(.WORD_W(64), .UPPERCASE(1), .EMIT_PREFIX(0)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[2]), .o_ready(rdy[2]),
        .i_word(wd), .o_char_valid(cv[2]), .i_char_ready(crdy[2]),
        .o_char(ch[2]), .o_last(lst[2]), .o_busy(bsy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected character stream for a word, from the hex-text rules.
    task automatic model(input int d, input logic [63:0] w,
                         output byte unsigned q[$]);
        int nib;
        int upper;
        int n;
        q = {};
        nib   = (d == 2) ? 16 : 4;
        upper = (d != 1);
        if (d == 1) begin
            q.push_back(8'h30);
            q.push_back(8'h78);
        end
        for (int i = nib - 1; i >= 0; i--) begin
            n = int'((w >> (4 * i)) & 64'hF);
            if (n < 10) q.push_back(byte'(48 + n));
            else        q.push_back(byte'((upper ? 65 : 97) + n - 10));
        end
    endtask

    // mode 0: sink always ready; 1: random ready; 2: stall 3 cycles on 2nd char
    // nxt_valid: present next word during the transfer to test busy-ignore
    task automatic run_word(input int d, input logic [63:0] w,
                            input int mode, input bit nxt_valid,
                            input logic [63:0] nxt_w);
        byte unsigned q[$];
        int  idx;
        int  cyc;
        int  stall;
        bit  r;
        model(d, w, q);
        chk("idle_ready", 64'(rdy[d]), 64'd1);
        wd     = w;
        vld[d] = 1'b1;
        step();
        vld[d] = 1'b0;
        if (nxt_valid) begin
            wd     = nxt_w;
            vld[d] = 1'b1;
        end
        idx   = 0;
        cyc   = 0;
        stall = 0;
        while (idx < q.size() && cyc < 500) begin
            case (mode)
                1: r = 1'($urandom_range(0, 1));
                2: begin
                    r = !(idx == 1 && stall < 3);
                    if (!r) stall++;
                end
                default: r = 1'b1;
            endcase
            crdy[d] = r;
            chk("char_valid", 64'(cv[d]), 64'd1);
            chk("char", 64'(ch[d]), 64'(q[idx]));
            chk("last", 64'(lst[d]), 64'(idx == q.size() - 1));
            chk("busy_not_ready", 64'(rdy[d]), 64'd0);
            step();
            if (r) idx++;
            cyc++;
        end
        crdy[d] = 1'b0;
        chk("transfers_done", 64'(idx), 64'(q.size()));
        chk("post_ready", 64'(rdy[d]), 64'd1);
        chk("post_valid", 64'(cv[d]), 64'd0);
        chk("post_busy", 64'(bsy[d]), 64'd0);
    endtask

    initial begin
        vecs  = 0;
        errs  = 0;
        rst_n = 1'b0;
        wd    = '0;
        for (int i = 0; i < 3; i++) begin
            vld[i]  = 1'b0;
            crdy[i] = 1'b0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", 64'(rdy[i]), 64'd1);
            chk("rst_cvalid", 64'(cv[i]), 64'd0);
            chk("rst_char", 64'(ch[i]), 64'd0);
            chk("rst_last", 64'(lst[i]), 64'd0);
            chk("rst_busy", 64'(bsy[i]), 64'd0);
        end
        rst_n = 1'b1;
        step();

        run_word(0, 64'hBEEF, 0, 1'b0, 64'h0);
        run_word(0, 64'hBEEF, 2, 1'b0, 64'h0);
        run_word(1, 64'h00A5, 0, 1'b0, 64'h0);
        run_word(0, 64'hBEEF, 0, 1'b1, 64'h1234);
        run_word(0, 64'h1234, 0, 1'b0, 64'h0);

        // Reset in the middle of a word
        wd     = 64'hBEEF;
        vld[0] = 1'b1;
        step();
        vld[0]  = 1'b0;
        crdy[0] = 1'b1;
        step();
        step();
        chk("pre_rst_char", 64'(ch[0]), 64'h45);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cvalid", 64'(cv[0]), 64'd0);
        chk("rst_mid_ready", 64'(rdy[0]), 64'd1);
        #2;
        rst_n = 1'b1;
        step();
        chk("rel_ready", 64'(rdy[0]), 64'd1);
        chk("rel_cvalid", 64'(cv[0]), 64'd0);
        crdy[0] = 1'b0;
        run_word(0, 64'h0001, 0, 1'b0, 64'h0);

        run_word(2, 64'h0123456789ABCDEF, 1, 1'b0, 64'h0);
        for (int k = 0; k < 6; k++) begin
            run_word(0, 64'($urandom_range(0, 65535)), 1, 1'b0, 64'h0);
            run_word(1, 64'($urandom_range(0, 65535)), 1, 1'b0, 64'h0);
            run_word(2, {32'($urandom), 32'($urandom)}, 1, 1'b0, 64'h0);
        end
        run_word(1, 64'hFFFF, 2, 1'b0, 64'h0);
        run_word(2, 64'h0, 0, 1'b0, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
